instruction_fetch: RTL

Fetch stage of the 16-bit RISC core. Owns the program counter, drives it combinationally to the instruction memory, and captures the returned 16-bit instruction into an IF/ID register. It presents that register to the decoder with a valid/ready handshake. It also accepts PC redirects from the execute stage for branches and jumps, and squashes the in-flight instruction on a redirect.

---
 rtl/instruction_fetch_pkg.sv | 26 ++
 rtl/instruction_fetch_ifid_reg.sv | 27 ++
 rtl/instruction_fetch.sv | 94 +++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and constants for the 16-bit RISC core.
// Used by instruction_fetch and ifid_reg.
package instruction_fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;

    localparam logic [OPC_HI-OPC_LO:0] HALT_OPCODE = 4'hF;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID holding register: flush beats load, otherwise the contents hold.
// Contents are kept on flush; only the valid bit drops.
module ifid_reg
    import instruction_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output logic   valid,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC mux, RUN/HALT control and IF/ID slot.
// Halt-opcode detection is built only when FETCH_HALT_EN is defined.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            load, cap, flush;
    if_id_t          slot_d, slot_q;
    logic            unused_rpc0;

    assign unused_rpc0 = redirect_pc[0];
    assign load        = !id_valid || id_ready;
    assign imem_pc     = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        cap     = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[PC_W-1:1], 1'b0};
            state_d = RUN;
            flush   = 1'b1;
        end else if (load) begin
            unique case (state_q)
                RUN: begin
`ifdef FETCH_HALT_EN
                    if (is_halt(imem_instr)) begin
                        state_d = HALT;
                        flush   = 1'b1;
                    end else begin
                        cap  = 1'b1;
                        pc_d = pc_q + PC_W'(2);
                    end
`else
                    cap  = 1'b1;
                    pc_d = pc_q + PC_W'(2);
`endif
                end
                HALT: flush = 1'b1;
                default: ;
            endcase
        end
    end

    assign slot_d.pc    = pc_q;
    assign slot_d.instr = imem_instr;

    ifid_reg u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cap),
        .flush (flush),
        .d     (slot_d),
        .valid (id_valid),
        .q     (slot_q)
    );

    assign id_instr = slot_q.instr;
    assign id_pc    = slot_q.pc;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
